// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with occupancy count, thresholds and sticky error flags
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module sync_fifo_ctrl #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = (1 << ASIZE) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  input  logic             clr_err,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] LP_DEPTH = DEPTH[ASIZE:0];
  localparam logic [ASIZE:0] LP_AF    = AF_LEVEL[ASIZE:0];
  localparam logic [ASIZE:0] LP_AE    = AE_LEVEL[ASIZE:0];

  generate
    if (!((AE_LEVEL > 0) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
      $error("sync_fifo_ctrl: thresholds must satisfy 0 < AE_LEVEL < AF_LEVEL <= DEPTH");
    end
  endgenerate

  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [ASIZE-1:0] r_waddr;
  logic [ASIZE-1:0] r_raddr;
  logic [ASIZE:0]   r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  // Flags come only from the count register, so they never glitch on request inputs.
  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_wr_ok = winc & ~w_full;
  assign w_rd_ok = rinc & ~w_empty;

  always_ff @(posedge clk) begin
    if (rst_n && w_wr_ok) begin
      r_mem[r_waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_waddr <= '0;
      r_raddr <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) begin
        r_waddr <= r_waddr + 1'b1;
      end
      if (w_rd_ok) begin
        r_raddr <= r_raddr + 1'b1;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error in the same cycle as clr_err takes priority over the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (winc && w_full) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (rinc && w_empty) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata  = r_mem[r_raddr];
  assign rvalid = ~w_empty;
`else
  logic [DSIZE-1:0] r_rdata;
  logic             r_rvalid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_ok;
      if (w_rd_ok) begin
        r_rdata <= r_mem[r_raddr];
      end
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
`endif

  assign wfull         = w_full;
  assign rempty        = w_empty;
  assign walmost_full  = (r_count >= LP_AF);
  assign ralmost_empty = (r_count <= LP_AE);
  assign count         = r_count;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - directed self-checking bench for sync_fifo_ctrl
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       winc;
  logic [7:0] wdata;
  logic       rinc;
  logic       clr_err;
  logic [7:0] rdata;
  logic       rvalid;
  logic       wfull;
  logic       rempty;
  logic       walmost_full;
  logic       ralmost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  sync_fifo_ctrl #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
    .clr_err(clr_err), .rdata(rdata), .rvalid(rvalid), .wfull(wfull),
    .rempty(rempty), .walmost_full(walmost_full), .ralmost_empty(ralmost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pops one word and checks it at the point the active read mode presents it.
  task automatic read_expect(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk({tag, "_rdata"}, rdata, exp);
    chk({tag, "_rvalid"}, rvalid, 1);
    rinc = 1'b1;
    tick();
`else
    rinc = 1'b1;
    tick();
    chk({tag, "_rvalid"}, rvalid, 1);
    chk({tag, "_rdata"}, rdata, exp);
`endif
  endtask

  initial begin
    rst_n = 1'b0; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = 8'h00;

    // reset then idle
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_rempty", rempty, 1);
    chk("rst_wfull", wfull, 0);
    chk("rst_count", count, 0);
    chk("rst_rvalid", rvalid, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_rdata", rdata, 8'h00);
`endif
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_ralmost_empty", ralmost_empty, 1);
    chk("rst_walmost_full", walmost_full, 0);

    // fill 0x00..0x0F, thresholds at 14 and 16, AE up to 2
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1; wdata = 8'(i);
      tick();
      chk("fill_count", count, i + 1);
      chk("fill_walmost_full", walmost_full, (i + 1 >= 14) ? 1 : 0);
      chk("fill_wfull", wfull, (i + 1 == 16) ? 1 : 0);
      chk("fill_ralmost_empty", ralmost_empty, (i + 1 <= 2) ? 1 : 0);
    end

    // overflow while full: word rejected, flag sticky
    wdata = 8'hAA;
    tick();
    winc = 1'b0;
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);
    tick();
    chk("ovf_sticky", overflow, 1);
    chk("ovf_no_underflow", underflow, 0);

    for (int i = 0; i < 16; i++) begin
      read_expect("drain", 8'(i));
    end
    rinc = 1'b0;
    tick();
    chk("drain_rempty", rempty, 1);
    chk("drain_count", count, 0);
    chk("drain_rvalid_idle", rvalid, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("drain_rdata_hold", rdata, 8'h0F);
`endif
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_overflow", overflow, 0);

    // simultaneous access on empty: write taken, read rejected
    winc = 1'b1; rinc = 1'b1; wdata = 8'h55;
    tick();
    winc = 1'b0; rinc = 1'b0;
    chk("emp_both_count", count, 1);
    chk("emp_both_underflow", underflow, 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("emp_both_rvalid", rvalid, 1);
`else
    chk("emp_both_rvalid", rvalid, 0);
`endif
    read_expect("emp_both_read", 8'h55);
    rinc = 1'b0;
    tick();
    chk("emp_both_rempty", rempty, 1);

    // clear and new underflow in the same cycle: set wins
    rinc = 1'b1; clr_err = 1'b1;
    tick();
    rinc = 1'b0;
    chk("set_wins_underflow", underflow, 1);
    tick();
    clr_err = 1'b0;
    chk("clr_underflow", underflow, 0);

    // full with winc & rinc: read taken, write rejected
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1; wdata = 8'(8'h20 + i);
      tick();
    end
    chk("full2_wfull", wfull, 1);
    wdata = 8'hBB;
`ifdef SYNC_FIFO_FWFT_EN
    chk("full_both_rdata", rdata, 8'h20);
`endif
    rinc = 1'b1;
    tick();
    winc = 1'b0;
    chk("full_both_count", count, 15);
    chk("full_both_overflow", overflow, 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("full_both_rdata", rdata, 8'h20);
`endif
    for (int i = 1; i < 16; i++) begin
      read_expect("full_both_drain", 8'(8'h20 + i));
    end
    rinc = 1'b0;
    tick();
    chk("full_both_empty", count, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // wrap-around streaming at count 8
    for (int i = 0; i < 8; i++) begin
      winc = 1'b1; wdata = 8'(8'h40 + i);
      tick();
    end
    for (int k = 0; k < 40; k++) begin
      winc = 1'b1; rinc = 1'b1; wdata = 8'(8'h48 + k);
`ifdef SYNC_FIFO_FWFT_EN
      chk("wrap_rdata", rdata, 8'(8'h40 + k));
`endif
      tick();
      chk("wrap_count", count, 8);
`ifndef SYNC_FIFO_FWFT_EN
      chk("wrap_rdata", rdata, 8'(8'h40 + k));
`endif
    end
    rinc = 1'b0; wdata = 8'h99;
    tick();
    winc = 1'b0;
    chk("pre_rst_count", count, 9);

    // mid-operation reset with requests active
    rst_n = 1'b0; winc = 1'b1; rinc = 1'b1;
    tick();
    rst_n = 1'b1; winc = 1'b0; rinc = 1'b0;
    chk("midrst_count", count, 0);
    chk("midrst_rempty", rempty, 1);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_underflow", underflow, 0);
    chk("midrst_rvalid", rvalid, 0);
    tick();
    chk("midrst_idle_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock, parametrised FIFO for same-domain buffering. It is the companion to the dual-clock FIFO and keeps the same winc/rinc/wfull/rempty handshake so the two are drop-in compatible at block boundaries. Beyond the dual-clock FIFO, it adds:
- an exact occupancy count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags with a clear input;
- a registered read-valid strobe.

Parameters:
- DSIZE, 8, data width in bits.
- ASIZE, 4, address width; DEPTH = 2**ASIZE entries.
- AF_LEVEL, 2**ASIZE-2, walmost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, ralmost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- winc  input  1  write request.
- wdata  input  DSIZE  write data.
- rinc  input  1  read request.
- clr_err  input  1  clears overflow and underflow.
- rdata  output  DSIZE  read data.
- rvalid  output  1  rdata holds a newly popped word this cycle.
- wfull  output  1  count == DEPTH.
- rempty  output  1  count == 0.
- walmost_full  output  1  count >= AF_LEVEL.
- ralmost_empty  output  1  count <= AE_LEVEL.
- count  output  ASIZE+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.

Behaviour:
Clock and reset (already decided):
- One clock, clk. Reset rst_n is synchronous and active-low.
- Reset is sampled only at the clk rising edge. No asynchronous reset path.

Reset values:
- waddr = 0, raddr = 0, count = 0.
- rdata = 0, rvalid = 0, overflow = 0, underflow = 0.
- Resulting flags: rempty = 1, ralmost_empty = 1, wfull = 0, walmost_full = 0 (given AF_LEVEL > 0).
- Memory contents are not reset.
- Reset asserted mid-operation discards all stored data at the next edge. Requests in that cycle are ignored and raise no error flags.

Write and read acceptance:
- wr_ok = winc & !wfull. On wr_ok, mem[waddr] <= wdata and waddr increments, wrapping DEPTH-1 -> 0.
- rd_ok = rinc & !rempty. On rd_ok, rdata <= mem[raddr] and raddr increments with wrap. rvalid is 1 in the next cycle, otherwise 0.
- Read latency is 1 cycle. rdata holds its last value when there is no read.

Count update:
- count <= count + wr_ok - rd_ok.
- Simultaneous wr_ok and rd_ok leave count unchanged.
- All flags decode combinationally from the count register.

Boundary cases:
- Full with winc & rinc: the read is accepted, the write is rejected, overflow is set, and count goes to DEPTH-1.
- Empty with winc & rinc: the write is accepted, the read is rejected, underflow is set, and count goes to 1. No bypass path.
- Any winc while wfull sets overflow. Any rinc while rempty sets underflow. Pointers and memory are unchanged.

Error flags:
- overflow and underflow are sticky until clr_err = 1 or reset.
- If clr_err and a new error occur in the same cycle, the set wins.

Elaboration checks:
- Require 0 < AE_LEVEL < AF_LEVEL <= DEPTH. Violations are an elaboration $error.

Optional Feature:
Macro: SYNC_FIFO_FWFT_EN (first-word-fall-through).

When defined:
- rdata = mem[raddr] combinationally. It shows the head word whenever rempty = 0.
- rd_ok pops the head with no added latency.
- rvalid = !rempty, combinational.
- A write to an empty FIFO makes the word visible on rdata in the next cycle.
- Reset, count, flag and error behaviour are unchanged.

When not defined:
- The registered 1-cycle read path described in Behaviour applies.

Test Plan:
All scenarios use DSIZE=8, ASIZE=4 (DEPTH=16), AF_LEVEL=14, AE_LEVEL=2.

1. Reset then idle: rst_n low for 2 edges, then high → rempty=1, wfull=0, count=0, rvalid=0, rdata=0x00, overflow=0, underflow=0.
2. Fill and drain: write 0x00..0x0F on 16 cycles → walmost_full first at count=14, wfull at count=16. Then read 16 times → rdata 0x00..0x0F in order, each 1 cycle after its rinc, rempty=1 at the end.
3. Overflow: when full, winc with 0xAA → count stays 16 and overflow=1 sticky. Drain confirms 0xAA is absent. clr_err pulse → overflow=0.
4. Underflow and simultaneous access on empty: winc=rinc=1 with wdata=0x55 → count=1, underflow=1, rvalid=0. Next read → rdata=0x55.
5. Wrap-around: 40 cycles of continuous winc & rinc at count=8 → count stays 8 throughout and the data sequence is preserved across pointer wrap.
6. Mid-operation reset at count=9, with winc=1 in the reset cycle → count=0, rempty=1, no overflow, no underflow. With SYNC_FIFO_FWFT_EN defined, repeat test 2 → rdata equals the head word with 0 latency.
